// File: rtl/bp_nonsynth_io_load_mux_pkg.sv
// Shared types for the I/O load mux: processor config selector, memory
// command message layout and the loader source indices.
package bp_nonsynth_io_load_mux_pkg;

   typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

   localparam int paddr_width_p     = 40;
   localparam int cce_block_width_p = 64;
   localparam int lce_id_width_p    = 4;
   localparam int lce_assoc_p       = 8;

   typedef struct packed {
      logic [3:0]                     msg_type;
      logic [paddr_width_p-1:0]       addr;
      logic [2:0]                     size;
      logic [lce_id_width_p-1:0]      lce_id;
      logic [$clog2(lce_assoc_p)-1:0] way_id;
      logic [cce_block_width_p-1:0]   data;
   } bp_cce_mem_msg_s;

   localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

   localparam logic e_load_src_cfg = 1'b0;
   localparam logic e_load_src_nbf = 1'b1;

endpackage

// File: rtl/bp_nonsynth_io_tag_fifo.sv
// 1-bit source-id FIFO remembering which loader owns each in-flight command.
// Full/empty come from pointer equality qualified by a per-pointer wrap bit.
module bp_nonsynth_io_tag_fifo #(
   parameter  int depth_p  = 8,
   localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic v_i,
   input  logic data_i,
   input  logic yumi_i,
   output logic data_o,
   output logic full_o,
   output logic empty_o
);

   localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(depth_p - 1);
   localparam logic [ptr_w_lp-1:0] one_lp  = ptr_w_lp'(1);

   logic [depth_p-1:0]  r_mem;
   logic [ptr_w_lp-1:0] r_wptr, r_rptr;
   logic                r_wwrap, r_rwrap;
   logic                w_ptr_eq;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_mem   <= '0;
         r_wptr  <= '0;
         r_wwrap <= 1'b0;
      end else if (v_i) begin
         r_mem[r_wptr] <= data_i;
         if (r_wptr == last_lp) begin
            r_wptr  <= '0;
            r_wwrap <= ~r_wwrap;
         end else begin
            r_wptr  <= r_wptr + one_lp;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rptr  <= '0;
         r_rwrap <= 1'b0;
      end else if (yumi_i) begin
         if (r_rptr == last_lp) begin
            r_rptr  <= '0;
            r_rwrap <= ~r_rwrap;
         end else begin
            r_rptr  <= r_rptr + one_lp;
         end
      end
   end

   assign w_ptr_eq = (r_wptr == r_rptr);
   assign full_o   = w_ptr_eq & (r_wwrap != r_rwrap);
   assign empty_o  = w_ptr_eq & (r_wwrap == r_rwrap);
   assign data_o   = r_mem[r_rptr];

endmodule

// File: rtl/bp_nonsynth_io_load_mux.sv
// Merges the cfg and nbf loaders onto one host-link command channel and
// steers each in-order response back to the loader that issued it.
module bp_nonsynth_io_load_mux
   import bp_nonsynth_io_load_mux_pkg::*;
#(
   parameter  bp_params_e bp_params_p       = e_bp_default_cfg,
   parameter  int         num_outstanding_p = 8,
   parameter  bit         rr_p              = 1'b1,
   localparam int         cnt_w_lp          = $clog2(num_outstanding_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  bp_cce_mem_msg_s [1:0]        src_cmd_i,
   input  logic [1:0]                   src_cmd_v_i,
   output logic [1:0]                   src_cmd_ready_o,
   output bp_cce_mem_msg_s              src_resp_o,
   output logic [1:0]                   src_resp_v_o,
   input  logic [1:0]                   src_resp_ready_i,
   output bp_cce_mem_msg_s              io_cmd_o,
   output logic                         io_cmd_v_o,
   input  logic                         io_cmd_ready_i,
   input  bp_cce_mem_msg_s              io_resp_i,
   input  logic                         io_resp_v_i,
   output logic                         io_resp_yumi_o,
   output logic [cnt_w_lp-1:0]          outstanding_o,
   output logic                         idle_o,
   output logic                         orphan_resp_o
);

   if (num_outstanding_p < 1 || bp_params_p != e_bp_default_cfg) begin : g_bad_cfg
      $error("bp_nonsynth_io_load_mux: unsupported configuration");
   end

   localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

   logic                r_rst_meta, r_rst_n;
   logic                r_last_grant, r_orphan;
   logic [cnt_w_lp-1:0] r_cnt;
   logic                w_grant, w_head, w_full, w_empty, w_push, w_pop;

   // Assert asynchronously, release two edges later so all state leaves reset together.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   always_comb begin
      w_grant = e_load_src_cfg;
      if (src_cmd_v_i[1] & ~src_cmd_v_i[0])
         w_grant = e_load_src_nbf;
      else if ((&src_cmd_v_i) && rr_p && (r_last_grant == e_load_src_cfg))
         w_grant = e_load_src_nbf;
   end

   assign io_cmd_o   = src_cmd_i[w_grant];
   assign io_cmd_v_o = r_rst_n & (|src_cmd_v_i) & ~w_full;
   assign w_push     = io_cmd_v_o & io_cmd_ready_i;

   always_comb begin
      src_cmd_ready_o          = '0;
      src_cmd_ready_o[w_grant] = r_rst_n & io_cmd_ready_i & ~w_full;
   end

   assign src_resp_o = io_resp_i;

   always_comb begin
      src_resp_v_o         = '0;
      src_resp_v_o[w_head] = r_rst_n & io_resp_v_i & ~w_empty;
   end

   assign io_resp_yumi_o = src_resp_v_o[w_head] & src_resp_ready_i[w_head];
   assign w_pop          = io_resp_yumi_o;

   bp_nonsynth_io_tag_fifo #(.depth_p(num_outstanding_p)) u_tag_fifo (
      .clk_i    (clk_i),
      .reset_n_i(r_rst_n),
      .v_i      (w_push),
      .data_i   (w_grant),
      .yumi_i   (w_pop),
      .data_o   (w_head),
      .full_o   (w_full),
      .empty_o  (w_empty)
   );

   // Grant history moves only on handshake, so a stalled winner keeps the grant.
   always_ff @(posedge clk_i or negedge r_rst_n) begin
      if (!r_rst_n)    r_last_grant <= e_load_src_nbf;
      else if (w_push) r_last_grant <= w_grant;
   end

   always_ff @(posedge clk_i or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_cnt <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + cnt_one_lp;
            2'b01:   r_cnt <= r_cnt - cnt_one_lp;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge r_rst_n) begin
      if (!r_rst_n)                  r_orphan <= 1'b0;
      else if (io_resp_v_i & w_empty) r_orphan <= 1'b1;
   end

   assign outstanding_o = r_cnt;
   assign idle_o        = (r_cnt == '0);
   assign orphan_resp_o = r_orphan;

endmodule

// File: tb/tb_bp_nonsynth_io_load_mux.sv
// Directed bench: u_a is the default round-robin, 8-deep mux; u_b is a
// fixed-priority, 2-deep mux used for full-condition and priority checks.
module tb_bp_nonsynth_io_load_mux;
   import bp_nonsynth_io_load_mux_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset_n;
   bp_cce_mem_msg_s [1:0] src_cmd;
   logic [1:0]            src_cmd_v, src_resp_ready;
   logic                  io_cmd_ready, io_resp_v;
   bp_cce_mem_msg_s       io_resp;

   bp_cce_mem_msg_s a_src_resp, a_io_cmd, b_src_resp, b_io_cmd;
   logic [1:0]      a_cmd_rdy, a_resp_v, b_cmd_rdy, b_resp_v;
   logic            a_cmd_v, a_yumi, a_idle, a_orphan;
   logic            b_cmd_v, b_yumi, b_idle, b_orphan;
   logic [3:0]      a_out;
   logic [1:0]      b_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bp_nonsynth_io_load_mux #(.num_outstanding_p(8), .rr_p(1'b1)) u_a (
      .clk_i(clk), .reset_n_i(reset_n),
      .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v), .src_cmd_ready_o(a_cmd_rdy),
      .src_resp_o(a_src_resp), .src_resp_v_o(a_resp_v), .src_resp_ready_i(src_resp_ready),
      .io_cmd_o(a_io_cmd), .io_cmd_v_o(a_cmd_v), .io_cmd_ready_i(io_cmd_ready),
      .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(a_yumi),
      .outstanding_o(a_out), .idle_o(a_idle), .orphan_resp_o(a_orphan));

   bp_nonsynth_io_load_mux #(.num_outstanding_p(2), .rr_p(1'b0)) u_b (
      .clk_i(clk), .reset_n_i(reset_n),
      .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v), .src_cmd_ready_o(b_cmd_rdy),
      .src_resp_o(b_src_resp), .src_resp_v_o(b_resp_v), .src_resp_ready_i(src_resp_ready),
      .io_cmd_o(b_io_cmd), .io_cmd_v_o(b_cmd_v), .io_cmd_ready_i(io_cmd_ready),
      .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(b_yumi),
      .outstanding_o(b_out), .idle_o(b_idle), .orphan_resp_o(b_orphan));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bp_cce_mem_msg_s mk(input logic [7:0] n);
      mk          = '0;
      mk.msg_type = 4'h1;
      mk.addr     = 40'h1000 + 40'(n);
      mk.data     = {8{n}};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      src_cmd        = '0;
      src_cmd_v      = 2'b00;
      src_resp_ready = 2'b11;
      io_cmd_ready   = 1'b1;
      io_resp_v      = 1'b0;
      io_resp        = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      // Reset behaviour: outputs gated while reset is held, even with activity on inputs.
      idle_inputs();
      reset_n = 1'b0;
      #2;
      src_cmd_v = 2'b11;
      io_resp_v = 1'b1;
      settle();
      chk("rst_cmd_rdy",  a_cmd_rdy, 2'b00);
      chk("rst_cmd_v",    a_cmd_v,   1'b0);
      chk("rst_resp_v",   a_resp_v,  2'b00);
      chk("rst_yumi",     a_yumi,    1'b0);
      chk("rst_out",      a_out,     4'd0);
      chk("rst_idle",     a_idle,    1'b1);
      chk("rst_orphan",   a_orphan,  1'b0);
      do_reset();

      // Cfg-only traffic: three commands, then three responses.
      src_cmd[0] = mk(8'hA1);
      src_cmd_v  = 2'b01;
      for (int i = 0; i < 3; i++) begin
         src_cmd[0] = mk(8'(8'hA1 + i));
         settle();
         chk("cfg_rdy",   a_cmd_rdy,     2'b01);
         chk("cfg_data",  a_io_cmd.data, {8{8'(8'hA1 + i)}});
         chk("cfg_out",   a_out,         4'(i));
         step();
      end
      src_cmd_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("cfg_wait_out",  a_out,   4'd3);
         chk("cfg_wait_idle", a_idle,  1'b0);
         chk("cfg_wait_cmdv", a_cmd_v, 1'b0);
         step();
      end
      io_resp_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io_resp = mk(8'(8'hC1 + i));
         settle();
         chk("cfg_resp_v",    a_resp_v,        2'b01);
         chk("cfg_yumi",      a_yumi,          1'b1);
         chk("cfg_resp_data", a_src_resp.data, {8{8'(8'hC1 + i)}});
         chk("cfg_resp_out",  a_out,           4'(3 - i));
         step();
      end
      io_resp_v = 1'b0;
      settle();
      chk("cfg_end_out",  a_out,  4'd0);
      chk("cfg_end_idle", a_idle, 1'b1);
      chk("cfg_orphan",   a_orphan, 1'b0);
      do_reset();

      // Contention: u_a alternates 0,1,0,1; u_b (fixed priority, depth 2) takes 0,0 then fills.
      src_cmd[0] = mk(8'h10);
      src_cmd[1] = mk(8'h20);
      src_cmd_v  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_rdy",  a_cmd_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_data", a_io_cmd.data, (i % 2 == 0) ? {8{8'h10}} : {8{8'h20}});
         chk("fp_rdy",  b_cmd_rdy, (i < 2) ? 2'b01 : 2'b00);
         chk("fp_cmdv", b_cmd_v,   (i < 2) ? 1'b1 : 1'b0);
         step();
      end
      src_cmd_v = 2'b00;
      io_resp_v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_resp_v", a_resp_v, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end
      io_resp_v = 1'b0;
      settle();
      chk("rr_idle", a_idle, 1'b1);
      do_reset();

      // Full on u_b: pop and new command in the same cycle, command waits a cycle.
      src_cmd[0] = mk(8'h30);
      src_cmd_v  = 2'b01;
      repeat (2) step();
      settle();
      chk("full_rdy",  b_cmd_rdy, 2'b00);
      chk("full_cmdv", b_cmd_v,   1'b0);
      chk("full_out",  b_out,     2'd2);
      step();
      io_resp_v = 1'b1;
      settle();
      chk("full_pop_yumi", b_yumi,    1'b1);
      chk("full_pop_rdy",  b_cmd_rdy, 2'b00);
      step();
      io_resp_v = 1'b0;
      settle();
      chk("full_next_out", b_out,     2'd1);
      chk("full_next_rdy", b_cmd_rdy, 2'b01);
      step();
      settle();
      chk("full_refill_out", b_out, 2'd2);
      do_reset();

      // Response backpressure on an nbf-owned head.
      src_cmd[1] = mk(8'h40);
      src_cmd_v  = 2'b10;
      settle();
      chk("bp_rdy", a_cmd_rdy, 2'b10);
      step();
      src_cmd_v      = 2'b00;
      io_resp_v      = 1'b1;
      src_resp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_stall_yumi", a_yumi,   1'b0);
         chk("bp_stall_v",    a_resp_v, 2'b10);
         chk("bp_stall_out",  a_out,    4'd1);
         step();
      end
      src_resp_ready = 2'b11;
      settle();
      chk("bp_go_yumi", a_yumi, 1'b1);
      step();
      io_resp_v = 1'b0;
      settle();
      chk("bp_go_out", a_out, 4'd0);
      do_reset();

      // Orphan response: flag sets after the edge, never consumed, sticky.
      io_resp_v = 1'b1;
      settle();
      chk("orph_pre",  a_orphan, 1'b0);
      chk("orph_yumi", a_yumi,   1'b0);
      chk("orph_v",    a_resp_v, 2'b00);
      step();
      io_resp_v = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("orph_sticky", a_orphan, 1'b1);
         step();
      end
      do_reset();

      // Async reset with three in flight: clears without a clock edge.
      src_cmd[0] = mk(8'h50);
      src_cmd_v  = 2'b01;
      repeat (3) step();
      settle();
      chk("ar_pre_out", a_out, 4'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_out",  a_out,   4'd0);
      chk("ar_idle", a_idle,  1'b1);
      chk("ar_cmdv", a_cmd_v, 1'b0);
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_nonsynth_io_load_mux.md
# bp_nonsynth_io_load_mux

Two-source I/O command multiplexer that merges the CCE config loader and the NBF loader onto the single host-link command channel. It routes each in-order response back to the source that issued it. It sits directly upstream of the host-side `bp_me_cce_to_mem_link_bidir`. It also tracks outstanding requests so loaders can poll for quiescence, and it flags orphan responses.

## Interface

Parameters:
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `lce_assoc_p` for `bp_cce_mem_msg_s`.
- `num_outstanding_p`, default 8: maximum commands in flight; must be ≥1.
- `rr_p`, default 1: arbitration mode. 1 = round-robin; 0 = fixed priority, source 0 wins.

Ports (`msg` = `bp_cce_mem_msg_s`, width `cce_mem_msg_width_lp`; `cnt_w` = `$clog2(num_outstanding_p+1)`):
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `src_cmd_i`, in, 2×msg: source commands. [0] = cfg loader, [1] = nbf loader.
- `src_cmd_v_i`, in, 2: source command valid.
- `src_cmd_ready_o`, out, 2: source command ready.
- `src_resp_o`, out, msg: response broadcast to both sources.
- `src_resp_v_o`, out, 2: per-source response valid.
- `src_resp_ready_i`, in, 2: per-source response ready.
- `io_cmd_o`, out, msg: command to host link.
- `io_cmd_v_o`, out, 1: command valid.
- `io_cmd_ready_i`, in, 1: host-link command ready.
- `io_resp_i`, in, msg: response from host link.
- `io_resp_v_i`, in, 1: response valid.
- `io_resp_yumi_o`, out, 1: response consumed.
- `outstanding_o`, out, cnt_w: number of commands in flight.
- `idle_o`, out, 1: asserted when `outstanding_o == 0`.
- `orphan_resp_o`, out, 1: sticky error flag.

## Operation

- Command arbitration:
  - Eligible sources: those with `src_cmd_v_i[i]=1`.
  - `rr_p=1`: the source not equal to `last_grant_r` wins ties.
  - `rr_p=0`: source 0 always wins ties.
  - The winner's message drives `io_cmd_o`.
  - `io_cmd_v_o` = any valid & `~tag_full`.
  - `src_cmd_ready_o[g]` = `io_cmd_ready_i & ~tag_full`, for the winner `g` only. The loser's ready is 0.
- On command handshake (`io_cmd_v_o & io_cmd_ready_i`):
  - Push the 1-bit source id `g` into the tag FIFO.
  - Update `last_grant_r <= g`.
- Response routing:
  - Responses return in command order.
  - Head tag `h` selects the destination: `src_resp_v_o[h] = io_resp_v_i & ~tag_empty`. The other valid is 0.
  - `io_resp_yumi_o = io_resp_v_i & ~tag_empty & src_resp_ready_i[h]`.
  - On yumi, pop the tag FIFO.
- Orphan response:
  - `io_resp_v_i=1` while `tag_empty=1` sets `orphan_resp_o`. It stays set until reset.
  - The orphan response is never consumed: yumi stays 0.
- Counter arithmetic:
  - `outstanding_o` +1 on push, −1 on pop, unchanged when both occur.
  - It never exceeds `num_outstanding_p` and never underflows.

## Timing

- Reset (async assert, sync deassert inside the block):
  - Tag FIFO empty.
  - `outstanding_o=0`, `idle_o=1`, `orphan_resp_o=0`, `last_grant_r=1` (source 0 wins the first tie).
  - All `src_cmd_ready_o`, `src_resp_v_o`, `io_cmd_v_o`, `io_resp_yumi_o` are 0 while reset is asserted.
- Latency:
  - Command and response paths are purely combinational pass-through (0 cycles).
  - Tag, counter and grant state update at the `clk_i` rising edge.
- Full:
  - `tag_full` blocks the command path for that cycle, even if a pop occurs in the same cycle. There is no full-bypass.
  - A push into the freed slot happens the next cycle.
- Empty:
  - A push and a response in the same cycle do not bypass. The response waits one cycle.
- Reset mid-operation: all in-flight tags are discarded. The sources and host link are reset by the same net.
- Handshake rules:
  - A source must hold `src_cmd_i` stable while valid.
  - The grant may switch between sources only after a handshake, never while the current winner is stalled by `io_cmd_ready_i=0`. `last_grant_r` changes only on handshake, which guarantees this.

## Structure

- `bp_cce_mem_msg_s` comes from `bp_me_pkg` via `declare_bp_me_if`. Add no new typedefs.
- Source index localparams go in `bp_common_cfg_link_pkg`: `e_load_src_cfg=0`, `e_load_src_nbf=1`.
- One sub-module, `bp_nonsynth_io_tag_fifo`:
  - Depth `num_outstanding_p`, width 1.
  - Read/write pointers with wrap.
  - Full/empty from pointer equality plus a wrap bit.
  - Async active-low reset.
- The top level holds the arbiter, the grant register, the counter and the orphan flag.

## Test plan

- **Cfg-only traffic:** cfg issues 3 writes with `io_cmd_ready_i=1`, and responses return 2 cycles later. Required: `outstanding_o` goes 1,2,3 then back to 0; only `src_resp_v_o[0]` pulses; `idle_o` returns to 1.
- **Round-robin contention:** both sources hold valid for 4 handshakes with `rr_p=1`. Required: grant order 0,1,0,1; responses are routed 0,1,0,1.
- **Full:** `num_outstanding_p=2` with no responses. Required: the third command sees ready=0. One response plus a new cmd valid in the same cycle: cmd ready stays 0 that cycle and the command is accepted the next cycle.
- **Response backpressure:** head tag is 1 and `src_resp_ready_i[1]=0` for 5 cycles. Required: `io_resp_yumi_o=0` for those cycles and the counter holds. When ready rises, pop in the same cycle.
- **Orphan response:** assert `io_resp_v_i` with an empty FIFO. Required: `orphan_resp_o` is set the next cycle and stays set; yumi stays 0.
- **Async reset mid-flight:** with 3 outstanding, pulse `reset_n_i` low between clock edges. Required: `outstanding_o=0` and `idle_o=1` immediately, with no clock edge needed.
